// File: rtl/core_handshake_pkg.sv
// Shared types and default parameter values for the core ready/done handshake array.
package core_handshake_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        BACKOFF = 3'd2,
        DONE    = 3'd3,
        FAIL    = 3'd4
    } ch_state_e;

    localparam int unsigned DEF_NUM_CH             = 4;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES     = 1024;
    localparam int unsigned DEF_RETRY_LIMIT        = 3;
    localparam int unsigned DEF_BACKOFF_CYCLES     = 8;

    // Bits needed to hold 0..maxval; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/core_handshake_channel.sv
// One handshake channel: request FSM with timeout timer, backoff timer and retry counter.
module core_handshake_channel
    import core_handshake_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned RETRY_LIMIT    = DEF_RETRY_LIMIT,
    parameter int unsigned BACKOFF_CYCLES = DEF_BACKOFF_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic lock_stable,
    input  logic pll_core_locked,
    input  logic enable,
    input  logic rearm,
    input  logic done,
    output logic valid,
    output logic done_sticky,
    output logic fail_sticky
);

    localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned RW = cnt_width(RETRY_LIMIT);
    localparam int unsigned BW = cnt_width(BACKOFF_CYCLES);

    localparam bit            TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TIMER_LAST = TIMEOUT_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [RW-1:0] RETRY_MAX  = RW'(RETRY_LIMIT);
    localparam logic [BW-1:0] BO_LAST    = (BACKOFF_CYCLES != 0) ? BW'(BACKOFF_CYCLES - 1) : '0;

    ch_state_e     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [BW-1:0] bo_q,    bo_d;

    // Next-state logic; done in REQ takes priority over every other event.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        bo_d    = bo_q;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                retry_d = '0;
                bo_d    = '0;
                if (enable && lock_stable) state_d = REQ;
            end
            REQ: begin
                if (done) begin
                    state_d = DONE;
                end else if (!pll_core_locked || !enable) begin
                    state_d = IDLE;
                    timer_d = '0;
                    retry_d = '0;
                end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
                    timer_d = '0;
                    if (retry_q < RETRY_MAX) begin
                        state_d = BACKOFF;
                        retry_d = retry_q + 1'b1;
                        bo_d    = '0;
                    end else begin
                        state_d = FAIL;
                    end
                end else if (TIMEOUT_EN) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            BACKOFF: begin
                if (!pll_core_locked || !enable) begin
                    state_d = IDLE;
                    timer_d = '0;
                    retry_d = '0;
                end else if (bo_q == BO_LAST) begin
                    state_d = REQ;
                    timer_d = '0;
                end else begin
                    bo_d = bo_q + 1'b1;
                end
            end
            DONE: begin
                if (rearm) state_d = IDLE;
            end
            FAIL: begin
                if (rearm) begin
                    state_d = IDLE;
                    retry_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            retry_q <= '0;
            bo_q    <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            bo_q    <= bo_d;
        end
    end

    assign valid       = (state_q == REQ) && pll_core_locked && lock_stable && !done;
    assign done_sticky = (state_q == DONE);
    assign fail_sticky = (state_q == FAIL);

endmodule

// File: rtl/core_ready_handshake_array.sv
// Multi-channel core-to-bridge ready/done handshake: lock qualifier, channel array, aggregates.
module core_ready_handshake_array
    import core_handshake_pkg::*;
#(
    parameter int unsigned NUM_CH             = DEF_NUM_CH,
    parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES,
    parameter int unsigned RETRY_LIMIT        = DEF_RETRY_LIMIT,
    parameter int unsigned BACKOFF_CYCLES     = DEF_BACKOFF_CYCLES
) (
    input  logic              bridge_clk,
    input  logic              reset_n,
    input  logic              pll_core_locked,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] rearm,
    input  logic [NUM_CH-1:0] req_done,
    output logic [NUM_CH-1:0] req_valid,
    output logic [NUM_CH-1:0] ch_done,
    output logic [NUM_CH-1:0] ch_fail,
    output logic              lock_stable,
    output logic              all_done,
    output logic              any_fail
);

    localparam int unsigned   LW       = cnt_width(LOCK_STABLE_CYCLES);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_STABLE_CYCLES);

    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          lock_stable_q, lock_stable_d;
    logic          all_done_q, all_done_d;
    logic          any_fail_q, any_fail_d;

    // Lock counter saturates at the threshold and restarts on any lock drop.
    always_comb begin
        lock_cnt_d    = lock_cnt_q;
        lock_stable_d = pll_core_locked && (lock_cnt_q == LOCK_MAX);
        if (!pll_core_locked)           lock_cnt_d = '0;
        else if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
    end

    // Lock qualifier registers.
    always_ff @(posedge bridge_clk) begin
        if (!reset_n) begin
            lock_cnt_q    <= '0;
            lock_stable_q <= 1'b0;
        end else begin
            lock_cnt_q    <= lock_cnt_d;
            lock_stable_q <= lock_stable_d;
        end
    end

    assign lock_stable = lock_stable_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        core_handshake_channel #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .RETRY_LIMIT    (RETRY_LIMIT),
            .BACKOFF_CYCLES (BACKOFF_CYCLES)
        ) u_ch (
            .clk             (bridge_clk),
            .reset_n         (reset_n),
            .lock_stable     (lock_stable_q),
            .pll_core_locked (pll_core_locked),
            .enable          (ch_enable[i]),
            .rearm           (rearm[i]),
            .done            (req_done[i]),
            .valid           (req_valid[i]),
            .done_sticky     (ch_done[i]),
            .fail_sticky     (ch_fail[i])
        );
    end

    // Aggregates; disabled channels are treated as don't-care for all_done.
    always_comb begin
        all_done_d = (|ch_enable) && ((ch_done | ~ch_enable) == '1);
        any_fail_d = |ch_fail;
    end

    // Aggregate registers, one cycle behind the channel state.
    always_ff @(posedge bridge_clk) begin
        if (!reset_n) begin
            all_done_q <= 1'b0;
            any_fail_q <= 1'b0;
        end else begin
            all_done_q <= all_done_d;
            any_fail_q <= any_fail_d;
        end
    end

    assign all_done = all_done_q;
    assign any_fail = any_fail_q;

endmodule

// File: tb/tb_core_ready_handshake_array.sv
// Directed scoreboard bench for core_ready_handshake_array.
module tb_core_ready_handshake_array;

    localparam int NCH = 4;
    localparam int LCK = 16;
    localparam int TMO = 20;
    localparam int RTY = 2;
    localparam int BKO = 8;

    logic           bridge_clk = 1'b0;
    logic           reset_n;
    logic           pll_core_locked;
    logic [NCH-1:0] ch_enable;
    logic [NCH-1:0] rearm;
    logic [NCH-1:0] req_done;
    logic [NCH-1:0] req_valid;
    logic [NCH-1:0] ch_done;
    logic [NCH-1:0] ch_fail;
    logic           lock_stable;
    logic           all_done;
    logic           any_fail;

    always #5 bridge_clk = ~bridge_clk;

    core_ready_handshake_array #(
        .NUM_CH             (NCH),
        .LOCK_STABLE_CYCLES (LCK),
        .TIMEOUT_CYCLES     (TMO),
        .RETRY_LIMIT        (RTY),
        .BACKOFF_CYCLES     (BKO)
    ) dut (
        .bridge_clk      (bridge_clk),
        .reset_n         (reset_n),
        .pll_core_locked (pll_core_locked),
        .ch_enable       (ch_enable),
        .rearm           (rearm),
        .req_done        (req_done),
        .req_valid       (req_valid),
        .ch_done         (ch_done),
        .ch_fail         (ch_fail),
        .lock_stable     (lock_stable),
        .all_done        (all_done),
        .any_fail        (any_fail)
    );

    typedef enum int {S_VALID, S_DONE, S_FAIL, S_LOCK, S_ALLD, S_ANYF} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            S_VALID: return 32'(req_valid);
            S_DONE:  return 32'(ch_done);
            S_FAIL:  return 32'(ch_fail);
            S_LOCK:  return 32'(lock_stable);
            S_ALLD:  return 32'(all_done);
            default: return 32'(any_fail);
        endcase
    endfunction

    task automatic expect_val(input string tag, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic compare_all();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            n_cmp++;
            assert (o === e.exp) else begin
                n_mis++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge bridge_clk);
        #1;
    endtask

    task automatic expect_all_zero(input string tag);
        expect_val({tag, "_valid"}, S_VALID, 0);
        expect_val({tag, "_done"},  S_DONE,  0);
        expect_val({tag, "_fail"},  S_FAIL,  0);
        expect_val({tag, "_lock"},  S_LOCK,  0);
        expect_val({tag, "_alld"},  S_ALLD,  0);
        expect_val({tag, "_anyf"},  S_ANYF,  0);
        compare_all();
    endtask

    // ch0 starting in its first REQ cycle: TMO request cycles, BKO idle
    // cycles, repeated for the whole retry budget, ending in the first FAIL cycle.
    task automatic run_retry_budget(input string tag);
        for (int w = 0; w <= RTY; w++) begin
            for (int c = 0; c < TMO; c++) begin
                expect_val({tag, "_req"}, S_VALID, 1);
                compare_all();
                step(1);
            end
            if (w < RTY) begin
                for (int c = 0; c < BKO; c++) begin
                    expect_val({tag, "_backoff"}, S_VALID, 0);
                    compare_all();
                    step(1);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; pll_core_locked = 1'b0;
        ch_enable = '0; rearm = '0; req_done = '0;
        step(3);
        expect_all_zero("reset");
        reset_n = 1'b1;

        // Lock qualification with a glitch restarting the count.
        ch_enable = 4'b0001; pll_core_locked = 1'b1;
        step(9);
        expect_val("lock_early", S_LOCK, 0); compare_all();
        pll_core_locked = 1'b0;
        step(1);
        expect_val("lock_glitch", S_LOCK, 0); compare_all();
        pll_core_locked = 1'b1;
        step(LCK);
        expect_val("lock_cnt_full", S_LOCK, 0);
        expect_val("lock_cnt_full_valid", S_VALID, 0); compare_all();
        step(1);
        expect_val("lock_stable", S_LOCK, 1);
        expect_val("lock_stable_valid", S_VALID, 0); compare_all();
        step(1);
        expect_val("first_req", S_VALID, 4'b0001); compare_all();

        // Done handshake.
        req_done = 4'b0001; #1;
        expect_val("done_drop_same_cycle", S_VALID, 0); compare_all();
        step(1); req_done = '0;
        expect_val("done_sticky", S_DONE, 4'b0001);
        expect_val("done_valid_low", S_VALID, 0);
        expect_val("done_alld_lag", S_ALLD, 0); compare_all();
        step(1);
        expect_val("all_done", S_ALLD, 1);
        expect_val("done_still", S_DONE, 4'b0001); compare_all();
        rearm = 4'b0001;
        step(1); rearm = '0;
        expect_val("rearm_idle_done", S_DONE, 0);
        expect_val("rearm_idle_valid", S_VALID, 0); compare_all();
        step(1);
        expect_val("rearm_rereq", S_VALID, 4'b0001);
        expect_val("rearm_alld", S_ALLD, 0); compare_all();

        // Timeout and retry exhaustion.
        run_retry_budget("tmo");
        expect_val("fail_sticky", S_FAIL, 4'b0001);
        expect_val("fail_valid", S_VALID, 0);
        expect_val("fail_anyf_lag", S_ANYF, 0); compare_all();
        step(1);
        expect_val("any_fail", S_ANYF, 1);
        expect_val("fail_hold", S_FAIL, 4'b0001); compare_all();
        step(4);
        expect_val("fail_valid_hold", S_VALID, 0);
        expect_val("fail_hold2", S_FAIL, 4'b0001); compare_all();
        ch_enable = '0; rearm = 4'b0001;
        step(1); rearm = '0;
        expect_val("fail_rearm", S_FAIL, 0); compare_all();
        step(1);
        expect_val("fail_rearm_anyf", S_ANYF, 0); compare_all();

        // Lock loss after one retry, then a fresh retry budget on relock.
        ch_enable = 4'b0001;
        step(1);
        expect_val("ll_req", S_VALID, 4'b0001); compare_all();
        step(TMO);
        expect_val("ll_backoff", S_VALID, 0); compare_all();
        step(BKO);
        expect_val("ll_retry_req", S_VALID, 4'b0001); compare_all();
        step(5);
        pll_core_locked = 1'b0; #1;
        expect_val("ll_valid_drop", S_VALID, 0); compare_all();
        step(1); pll_core_locked = 1'b1;
        expect_val("ll_lock_drop", S_LOCK, 0);
        expect_val("ll_idle", S_VALID, 0); compare_all();
        step(LCK);
        expect_val("ll_relock_pending", S_LOCK, 0); compare_all();
        step(1);
        expect_val("ll_relock", S_LOCK, 1);
        expect_val("ll_relock_valid", S_VALID, 0); compare_all();
        step(1);
        run_retry_budget("relock");
        expect_val("relock_fail", S_FAIL, 4'b0001); compare_all();
        ch_enable = '0; rearm = 4'b0001;
        step(1); rearm = '0;

        // ch1: done coincident with the timeout cycle.
        ch_enable = 4'b0010;
        step(1);
        expect_val("c1_req", S_VALID, 4'b0010);
        expect_val("c1_fail_clear", S_FAIL, 0); compare_all();
        step(TMO - 1);
        expect_val("c1_last_req", S_VALID, 4'b0010); compare_all();
        req_done = 4'b0010; #1;
        expect_val("c1_done_drop", S_VALID, 0); compare_all();
        step(1); req_done = '0;
        expect_val("c1_done", S_DONE, 4'b0010);
        expect_val("c1_valid_low", S_VALID, 0); compare_all();
        step(1);
        expect_val("c1_all_done", S_ALLD, 1); compare_all();
        step(BKO + 2);
        expect_val("c1_done_hold", S_DONE, 4'b0010);
        expect_val("c1_no_rereq", S_VALID, 0);
        expect_val("c1_no_fail", S_ANYF, 0); compare_all();
        rearm = 4'b0010;
        step(1); rearm = '0;
        expect_val("c1_rearm_done", S_DONE, 0);
        expect_val("c1_rearm_valid", S_VALID, 0); compare_all();
        step(1);
        expect_val("c1_rereq", S_VALID, 4'b0010); compare_all();

        // Reset in ch2 BACKOFF with ch3 DONE.
        ch_enable = 4'b1100;
        step(1);
        expect_val("c23_req", S_VALID, 4'b1100); compare_all();
        req_done = 4'b1000; #1;
        expect_val("c3_done_drop", S_VALID, 4'b0100); compare_all();
        step(1); req_done = '0;
        expect_val("c3_done", S_DONE, 4'b1000);
        expect_val("c2_still_req", S_VALID, 4'b0100); compare_all();
        step(TMO - 1);
        expect_val("c2_backoff", S_VALID, 0);
        expect_val("c3_done_hold", S_DONE, 4'b1000);
        expect_val("c23_alld", S_ALLD, 0); compare_all();
        step(3);
        reset_n = 1'b0;
        step(1);
        expect_all_zero("mid_reset");
        reset_n = 1'b1;
        step(1);
        expect_all_zero("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
